// File: rtl/signed_div_pkg.sv
// Shared types and constants for the iterative signed divider.
package signed_div_pkg;

  localparam int unsigned DIV_W   = 32;
  localparam int unsigned DIV_LAT = 33;
  localparam logic [DIV_W-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; 32'h80000000 maps to itself, read as unsigned.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/signed_div_step.sv
// One unsigned restoring shift/subtract iteration (purely combinational).
module div_step
  import signed_div_pkg::*;
(
  input  logic [DIV_W:0]   rem_in,
  input  logic [DIV_W-1:0] dvd_in,
  input  logic [DIV_W-1:0] dvs_in,
  output logic [DIV_W:0]   rem_out,
  output logic [DIV_W-1:0] dvd_out
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W+1:0] dvs_ext;
  logic             fits;

  always_comb begin
    shifted = {rem_in, dvd_in[DIV_W-1]};
    dvs_ext = {2'b00, dvs_in};
    fits    = (shifted >= dvs_ext);
    rem_out = fits ? (DIV_W+1)'(shifted - dvs_ext) : shifted[DIV_W:0];
    // Quotient bits shift in from the right as dividend bits leave on the left.
    dvd_out = {dvd_in[DIV_W-2:0], fits};
  end

endmodule

// File: rtl/signed_div.sv
// 32-bit signed divider: magnitude restoring division over 32 cycles, sign fix-up at the end.
module signed_div
  import signed_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIV_W-1:0]  x,
  input  logic [DIV_W-1:0]  y,
  output logic [DIV_W-1:0]  quot,
  output logic [DIV_W-1:0]  rem,
  output logic              busy,
  output logic              done,
  output logic              dbz
);

  state_t           state_q;
  logic [DIV_W:0]   prem_q;
  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] dvs_q;
  logic             sign_x_q;
  logic             sign_y_q;
  logic [4:0]       cnt_q;

  logic [DIV_W:0]   step_rem;
  logic [DIV_W-1:0] step_dvd;
  logic [DIV_W-1:0] quot_fix;
  logic [DIV_W-1:0] rem_fix;

  div_step u_step (
    .rem_in  (prem_q),
    .dvd_in  (dvd_q),
    .dvs_in  (dvs_q),
    .rem_out (step_rem),
    .dvd_out (step_dvd)
  );

  // Truncation toward zero: quotient sign from xor, remainder follows the dividend.
  always_comb begin
    quot_fix = (sign_x_q ^ sign_y_q) ? (~step_dvd + 1'b1) : step_dvd;
    rem_fix  = sign_x_q ? (~step_rem[DIV_W-1:0] + 1'b1) : step_rem[DIV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prem_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      cnt_q    <= '0;
      quot     <= '0;
      rem      <= '0;
      dbz      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (y == '0) begin
              quot    <= DBZ_QUOT;
              rem     <= x;
              dbz     <= 1'b1;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              dvd_q    <= abs_val(x);
              dvs_q    <= abs_val(y);
              sign_x_q <= x[DIV_W-1];
              sign_y_q <= y[DIV_W-1];
              prem_q   <= '0;
              cnt_q    <= '0;
              busy     <= 1'b1;
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= step_rem;
          dvd_q  <= step_dvd;
          cnt_q  <= cnt_q + 5'd1;
          // The final step's result feeds the fix-up directly, so DONE follows at once.
          if (cnt_q == 5'(DIV_LAT - 2)) begin
            quot    <= quot_fix;
            rem     <= rem_fix;
            dbz     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
